// File: rtl/faux_hd_sector_store_pkg.sv
// Shared types and constants for the faux HD sector store: FSM states, sector
// geometry and the synthetic-pattern word format used when FAUX_HD_PATTERN_EN is set.
package faux_hd_sector_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER_WR = 2'd1,
    ST_XFER_RD = 2'd2
  } state_e;

  localparam int SECTOR_WORDS = 128;
  localparam int PATTERN_HI_W = 16;

  // Unwritten sectors read back as {sector tag, word index} so a bench can tell
  // exactly which dword it was handed.
  function automatic logic [31:0] pattern_word(input logic [PATTERN_HI_W-1:0] sector_tag,
                                               input logic [6:0]              word_ptr);
    return {sector_tag, 16'(word_ptr)};
  endfunction

endpackage

// File: rtl/faux_hd_sector_ram.sv
// Single-port dword array for the faux HD store: synchronous write, combinational
// read at the same address. Contents are never reset.
module faux_hd_sector_ram #(
  parameter int ADDR_W      = 11,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/faux_hd_sector_store.sv
// Sector-addressed backing store behind the faux SATA HD command layer.
// Optional build macro FAUX_HD_PATTERN_EN: per-sector valid bits, unwritten sectors read as a pattern.
module faux_hd_sector_store
  import faux_hd_sector_store_pkg::*;
#(
  parameter int DEPTH_SECTORS = 16,
  parameter int SECTOR_WORDS  = faux_hd_sector_store_pkg::SECTOR_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_load,
  input  logic        cmd_write,
  input  logic [47:0] cmd_lba,
  input  logic [15:0] cmd_sector_count,
  input  logic        wr_stb,
  input  logic [31:0] wr_data,
  input  logic        rd_stb,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        sector_done,
  output logic        xfer_done,
  output logic        proto_err
);

  localparam int SP_W = $clog2(DEPTH_SECTORS);
  localparam int WP_W = $clog2(SECTOR_WORDS);
  localparam int AW   = SP_W + WP_W;

  state_e          r_state, w_next_state;
  logic [SP_W-1:0] r_sector_ptr;
  logic [WP_W-1:0] r_word_ptr;
  logic [16:0]     r_remaining;
  logic            r_sector_done, r_xfer_done, r_proto_err;
  logic            w_adv, w_mem_we, w_illegal, w_sector_end, w_last;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_mem_rdata;
  logic            w_unused_lba;

  assign w_addr       = {r_sector_ptr, r_word_ptr};
  assign w_unused_lba = ^cmd_lba;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // cmd_load overrides everything, including a same-cycle strobe.
  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_adv        = 1'b0;
    w_illegal    = 1'b0;
    if (cmd_load) begin
      w_next_state = cmd_write ? ST_XFER_WR : ST_XFER_RD;
    end else begin
      w_mem_we  = wr_stb && (r_state == ST_XFER_WR);
      w_adv     = w_mem_we || (rd_stb && (r_state == ST_XFER_RD));
      w_illegal = (wr_stb && (r_state != ST_XFER_WR)) ||
                  (rd_stb && (r_state != ST_XFER_RD));
    end
    w_sector_end = w_adv && (r_word_ptr == WP_W'(SECTOR_WORDS - 1));
    w_last       = w_sector_end && (r_remaining == 17'd1);
    if (w_last) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sector_ptr  <= '0;
      r_word_ptr    <= '0;
      r_remaining   <= '0;
      r_sector_done <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_sector_done <= w_sector_end;
      r_xfer_done   <= w_last;
      if (cmd_load) begin
        r_sector_ptr <= cmd_lba[SP_W-1:0];
        r_word_ptr   <= '0;
        r_remaining  <= (cmd_sector_count == 16'd0) ? 17'h10000 : {1'b0, cmd_sector_count};
        r_proto_err  <= 1'b0;
      end else begin
        if (w_illegal) r_proto_err <= 1'b1;
        // Pointers wrap naturally: both widths are exact powers of two.
        if (w_adv) begin
          r_word_ptr <= r_word_ptr + 1'b1;
          if (w_sector_end) begin
            r_sector_ptr <= r_sector_ptr + 1'b1;
            r_remaining  <= r_remaining - 17'd1;
          end
        end
      end
    end
  end

  faux_hd_sector_ram #(
    .ADDR_W      (AW),
    .DEPTH_WORDS (DEPTH_SECTORS * SECTOR_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_addr),
    .i_wdata (wr_data),
    .o_rdata (w_mem_rdata)
  );

`ifdef FAUX_HD_PATTERN_EN
  logic [DEPTH_SECTORS-1:0] r_valid;
  logic [15:0]              r_lba_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_lba_tag <= '0;
    end else begin
      if (w_mem_we && w_sector_end) r_valid[r_sector_ptr] <= 1'b1;
      if (cmd_load)          r_lba_tag <= cmd_lba[15:0];
      else if (w_sector_end) r_lba_tag <= r_lba_tag + 16'd1;
    end
  end

  assign rd_data = r_valid[r_sector_ptr] ? w_mem_rdata : pattern_word(r_lba_tag, 7'(r_word_ptr));
`else
  assign rd_data = w_mem_rdata;
`endif

  assign busy        = (r_state != ST_IDLE);
  assign sector_done = r_sector_done;
  assign xfer_done   = r_xfer_done;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_faux_hd_sector_store.sv
// Bench for faux_hd_sector_store: transfer-level reference model compared every
// cycle, directed literal checks, then randomized transfers with aborts and illegal strobes.
module tb_faux_hd_sector_store;

  localparam int D = 16;
  localparam int W = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_load = 1'b0;
  logic        cmd_write = 1'b0;
  logic [47:0] cmd_lba = '0;
  logic [15:0] cmd_sector_count = '0;
  logic        wr_stb = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_stb = 1'b0;
  logic [31:0] rd_data;
  logic        busy, sector_done, xfer_done, proto_err;

  faux_hd_sector_store #(.DEPTH_SECTORS(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_load         (cmd_load),
    .cmd_write        (cmd_write),
    .cmd_lba          (cmd_lba),
    .cmd_sector_count (cmd_sector_count),
    .wr_stb           (wr_stb),
    .wr_data          (wr_data),
    .rd_stb           (rd_stb),
    .rd_data          (rd_data),
    .busy             (busy),
    .sector_done      (sector_done),
    .xfer_done        (xfer_done),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xd_count = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is (mode, start sector, total dwords, dwords done).
  logic [31:0] m_mem   [D*W];
  bit          m_known [D*W];
  bit          m_valid [D];
  int          m_mode;
  int          m_sec0;
  int          m_total;
  int          m_done;
  logic [15:0] m_tag;
  bit          m_sd, m_xd, m_perr;

  function automatic int m_addr();
    return ((m_sec0 + m_done / W) % D) * W + (m_done % W);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_sec0 = 0; m_total = 0; m_done = 0; m_tag = '0;
      m_sd = 0; m_xd = 0; m_perr = 0;
      for (int s = 0; s < D; s++) m_valid[s] = 0;
    end else begin
      m_sd = 0;
      m_xd = 0;
      if (cmd_load) begin
        m_mode  = cmd_write ? 1 : 2;
        m_sec0  = int'(cmd_lba % 48'(D));
        m_tag   = cmd_lba[15:0];
        m_total = ((cmd_sector_count == 0) ? 65536 : int'(cmd_sector_count)) * W;
        m_done  = 0;
        m_perr  = 0;
      end else begin
        if (wr_stb) begin
          if (m_mode == 1) begin
            int a;
            a = m_addr();
            m_mem[a] = wr_data;
            m_known[a] = 1;
            if ((m_done + 1) % W == 0) m_valid[a / W] = 1;
            m_done++;
            if (m_done % W == 0) m_sd = 1;
            if (m_done == m_total) begin m_xd = 1; m_mode = 0; end
          end else m_perr = 1;
        end
        if (rd_stb) begin
          if (m_mode == 2) begin
            m_done++;
            if (m_done % W == 0) m_sd = 1;
            if (m_done == m_total) begin m_xd = 1; m_mode = 0; end
          end else m_perr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int a;
    bit ok;
    logic [31:0] exp;
    a = m_addr();
`ifdef FAUX_HD_PATTERN_EN
    ok  = 1;
    exp = m_valid[a / W] ? m_mem[a] : {m_tag + 16'(m_done / W), 16'(m_done % W)};
`else
    ok  = m_known[a];
    exp = m_mem[a];
`endif
    cmp("m_busy", 32'(busy), 32'(m_mode != 0));
    cmp("m_sector_done", 32'(sector_done), 32'(m_sd));
    cmp("m_xfer_done", 32'(xfer_done), 32'(m_xd));
    cmp("m_proto_err", 32'(proto_err), 32'(m_perr));
    if (ok) cmp("m_rd_data", rd_data, exp);
    if (xfer_done) xd_count++;
  end

  task automatic step(input bit ld, input bit wr, input logic [47:0] lba, input logic [15:0] cnt,
                      input bit ws, input logic [31:0] wd, input bit rs);
    cmd_load = ld; cmd_write = wr; cmd_lba = lba; cmd_sector_count = cnt;
    wr_stb = ws; wr_data = wd; rd_stb = rs;
    @(posedge clk); #1;
    cmd_load = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, 0);
  endtask

  initial begin
    int xd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_proto_err", 32'(proto_err), 0);

    // Write LBA 3, one sector, data 0..127.
    step(1, 1, 48'd3, 16'd1, 0, '0, 0);
    cmp("wr_busy", 32'(busy), 1);
    for (int i = 0; i < W; i++) step(0, 0, '0, '0, 1, 32'(i), 0);
    cmp("wr_sector_done", 32'(sector_done), 1);
    cmp("wr_xfer_done", 32'(xfer_done), 1);
    cmp("wr_busy_drop", 32'(busy), 0);

    // Read it back.
    step(1, 0, 48'd3, 16'd1, 0, '0, 0);
    xd0 = xd_count;
    cmp("rd_busy", 32'(busy), 1);
    for (int i = 0; i < W; i++) begin
      cmp("rd_seq", rd_data, 32'(i));
      step(0, 0, '0, '0, 0, '0, 1);
    end
    idle();
    cmp("rd_xfer_done_once", 32'(xd_count - xd0), 1);

    // Two sectors starting at the top sector: the second wraps to sector 0.
    step(1, 1, 48'(D - 1), 16'd2, 0, '0, 0);
    for (int i = 0; i < 2 * W; i++) step(0, 0, '0, '0, 1, 32'(1000 + i), 0);
    idle();
    step(1, 0, 48'd0, 16'd1, 0, '0, 0);
    cmp("wrap_rd_w0", rd_data, 32'd1128);
    for (int i = 0; i < W; i++) step(0, 0, '0, '0, 0, '0, 1);

    // Leave the pointer parked on sector 0 word 0, then strobe illegally.
    step(1, 0, 48'(D - 1), 16'd1, 0, '0, 0);
    cmp("top_rd_w0", rd_data, 32'd1000);
    for (int i = 0; i < W; i++) step(0, 0, '0, '0, 0, '0, 1);
    step(0, 0, '0, '0, 1, 32'hDEAD_BEEF, 0);
    cmp("idle_wr_proto_err", 32'(proto_err), 1);
    cmp("idle_wr_mem_kept", rd_data, 32'd1128);
    step(1, 0, 48'd3, 16'd1, 0, '0, 0);
    cmp("proto_err_cleared", 32'(proto_err), 0);

    // Abort a read at word 40 with a colliding rd_stb.
    for (int i = 0; i < 40; i++) step(0, 0, '0, '0, 0, '0, 1);
    cmp("abort_w40", rd_data, 32'd40);
    xd0 = xd_count;
    step(1, 0, 48'd3, 16'd1, 0, '0, 1);
    cmp("abort_restart", rd_data, 32'd0);
    cmp("abort_no_err", 32'(proto_err), 0);
    for (int i = 0; i < W; i++) step(0, 0, '0, '0, 0, '0, 1);
    idle();
    cmp("abort_xd_count", 32'(xd_count - xd0), 1);

`ifdef FAUX_HD_PATTERN_EN
    step(1, 0, 48'h1234, 16'd1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 0, '0, 1);
    cmp("pattern_w5", rd_data, 32'h1234_0005);
    for (int i = 5; i < W; i++) step(0, 0, '0, '0, 0, '0, 1);
`endif

    // Randomized transfers with gaps, illegal strobes and aborts.
    for (int t = 0; t < 25; t++) begin
      bit          wr;
      int          total, k, iter, abort_at;
      logic [47:0] lba;
      wr  = 1'($urandom_range(0, 1));
      lba = {16'($urandom), $urandom};
      total = $urandom_range(1, 2) * W;
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, total - 1) : -1;
      step(1, wr, lba, 16'(total / W), 0, '0, 0);
      k = 0;
      iter = 0;
      while (k < total && k != abort_at && iter < 4 * total) begin
        int r;
        r = $urandom_range(0, 19);
        iter++;
        if (r < 4) idle();
        else if (r == 4) begin
          step(0, 0, '0, '0, 1, $urandom, 1);
          k++;
        end else begin
          step(0, 0, '0, '0, wr, $urandom, !wr);
          k++;
        end
      end
      if ($urandom_range(0, 3) == 0) step(0, 0, '0, '0, !wr, $urandom, wr);
      idle();
    end

    // Asynchronous reset mid-transfer.
    step(1, 1, 48'd5, 16'd1, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, '0, 1, 32'(i), 0);
    #1 rst_n = 1'b0;
    #1;
    cmp("async_rst_busy", 32'(busy), 0);
    cmp("async_rst_xd", 32'(xfer_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    idle();
    cmp("post_rst_proto_err", 32'(proto_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
